dmem_arbiter: RTL
=================

# dmem_arbiter

Shares the single-port data memory between the core's load/store port and a DMA/loader port. Requests use a request/grant handshake. The arbiter steers the memory address, write data and write enable from the granted requester, and returns registered read data one cycle later. It sits between the datapath's ALU-addressed load/store path and the data memory. The core stalls its PC whenever `cpu_req & ~cpu_gnt`.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `STARVE_LIMIT`, default 8: number of consecutive denied DMA cycles before DMA is forced to win. Legal range is 1..255.

Ports:
- `clk`  in  1  clock; rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  CPU access request.
- `cpu_we`  in  1  1 = store, 0 = load.
- `cpu_addr`  in  ADDR_W  CPU address.
- `cpu_wdata`  in  DATA_W  CPU store data.
- `cpu_gnt`  out  1  CPU access performed this cycle.
- `cpu_rvalid`  out  1  CPU load data valid.
- `cpu_rdata`  out  DATA_W  CPU load data.
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_gnt`, `dma_rvalid`, `dma_rdata`: same meanings and widths for the DMA port.
- `mem_we`  out  1  data memory write enable.
- `mem_addr`  out  ADDR_W  data memory address.
- `mem_wdata`  out  DATA_W  data memory write data.
- `mem_rdata`  in  DATA_W  data memory combinational read data.
- `starved`  out  1  starvation counter has reached STARVE_LIMIT.

## Operation
- **Grant rule.** Each cycle, at most one grant is asserted. The grant is combinational from the `*_req` inputs and the registered arbitration state. The access occurs in the grant cycle.
- **Arbitration state** consists of:
  - `last_gnt` (0 = CPU, 1 = DMA);
  - `starve_cnt`, which is clog2(STARVE_LIMIT+1) bits wide and saturates at STARVE_LIMIT;
  - the read-return registers `rd_owner[1:0]` and `rd_data`.
- **Requests:**
  - Only one requester active: that requester is granted.
  - No requests: no grant, and `mem_we` = 0.
  - Both requesting: the winner is chosen per Configuration. `starved` = 1 always overrides, and DMA wins.
- **Memory outputs:**
  - `mem_addr`/`mem_wdata` come from the granted port. When idle, they come from the CPU port.
  - `mem_we` = granted port's `we` & grant.
- **Starvation counter:**
  - Increments when `dma_req & ~dma_gnt`.
  - Clears when `dma_gnt` or `~dma_req`.
  - Holds at STARVE_LIMIT.
  - `starved` = (`starve_cnt` == STARVE_LIMIT).
- **Read return:**
  - A granted load captures `mem_rdata` into `rd_data` and sets `rd_owner` to the granted port.
  - The next cycle, the matching `*_rvalid` is 1 for exactly one cycle.
  - Both `*_rdata` outputs are driven from `rd_data`, and are valid only while the matching rvalid is 1.
  - Stores produce no rvalid.
- **Requester obligations:**
  - A requester holds req/we/addr/wdata stable until granted.
  - A requester may drop req before grant. The request is then abandoned, with no side effect.
- **Back-to-back accesses:** a new grant may occur in the same cycle as an rvalid for the previous load, giving one access per cycle.

## Timing
- **Reset values:**
  - `cpu_gnt`, `dma_gnt`, `cpu_rvalid`, `dma_rvalid`, `mem_we`, `starved` = 0.
  - `cpu_rdata`, `dma_rdata` = 0.
  - `last_gnt` = 1, so the CPU wins the first contention in round-robin mode.
  - `starve_cnt` = 0, `rd_owner` = none.
- **Reset mid-operation:** an asserted reset immediately clears any pending rvalid; the read is lost. Because the grant depends on `reset_n`, grants are 0 while reset is low.
- **Write latency:** the store commits at the rising edge that ends the grant cycle.
- **Read latency:** rvalid and data appear in the cycle after the grant.
- **Grant latency:**
  - CPU uncontended: 0 cycles.
  - DMA worst case under fixed priority: STARVE_LIMIT cycles of denial, then grant on the next cycle.
- **Update timing:** `last_gnt` updates only on cycles with a grant.

## Configuration
- `DMEM_ARB_RR_EN` defined: on contention, round-robin applies. The port not equal to `last_gnt` wins. The starvation override still applies but is never reached with the default limit.
- `DMEM_ARB_RR_EN` undefined: on contention, the CPU has strict priority. DMA wins only when `starved` = 1. `last_gnt` is still tracked but unused.

## Test plan
- **Reset:** assert `reset_n` = 0 mid-load (the cycle after a CPU load grant) → `cpu_rvalid` stays 0, and all grants are 0 while in reset.
- **Lone CPU traffic:** CPU store 0xDEADBEEF to 0x10, then load 0x10 → `cpu_gnt` = 1 in both cycles, `mem_we` = 1 only in the first, `cpu_rvalid` = 1 with `cpu_rdata` = 0xDEADBEEF in the third cycle.
- **Contention, RR undefined:** both request loads continuously, STARVE_LIMIT = 8 → CPU granted for cycles 0-7, `starved` = 1 in cycle 8 with DMA granted, CPU granted in cycle 9, `starve_cnt` = 1 in cycle 10.
- **Contention, `DMEM_ARB_RR_EN` defined:** both request continuously → grants alternate CPU, DMA, CPU, DMA starting with CPU, and `starved` never asserts.
- **Abandoned request:** DMA requests while the CPU is granted, then drops `dma_req` → `dma_gnt` never asserts, `starve_cnt` returns to 0, and no memory write occurs.
- **Interleaved loads:** CPU load 0x20 then DMA load 0x24 back-to-back → `cpu_rvalid` in cycle 1 with data[0x20], `dma_rvalid` in cycle 2 with data[0x24], and the rvalids are never simultaneous.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Request/grant bus between the core load/store port, the DMA port and the data memory.
// The arbiter takes the slave view; requesters and the memory model take the master view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory (CPU load/store vs DMA/loader).
// Define DMEM_ARB_RR_EN for round-robin on contention; default is CPU priority with starvation override.
module dmem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    dmem_arbiter_if.slave   bus,
    output logic            starved
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

    owner_e            rd_owner_q, rd_owner_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              last_gnt_q, last_gnt_d;
    logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
    logic              dma_wins;
    logic              cpu_gnt, dma_gnt;
    logic [ADDR_W-1:0] addr_sel;

    assign starved = (starve_cnt_q == LIMIT);

    // Contention tie-break; the starvation override applies in both modes.
`ifdef DMEM_ARB_RR_EN
    assign dma_wins = starved | ~last_gnt_q;
`else
    assign dma_wins = starved;
`endif

    // Grants are forced low while reset is held so nothing reaches memory.
    assign cpu_gnt = reset_n & bus.cpu_req & ~(bus.dma_req & dma_wins);
    assign dma_gnt = reset_n & bus.dma_req & (~bus.cpu_req | dma_wins);

    assign addr_sel      = dma_gnt ? bus.dma_addr : bus.cpu_addr;
    assign bus.mem_addr  = addr_sel;
    assign bus.mem_wdata = dma_gnt ? bus.dma_wdata : bus.cpu_wdata;
    assign bus.mem_we    = (cpu_gnt & bus.cpu_we) | (dma_gnt & bus.dma_we);

    assign bus.cpu_gnt    = cpu_gnt;
    assign bus.dma_gnt    = dma_gnt;
    assign bus.cpu_rvalid = (rd_owner_q == OWN_CPU);
    assign bus.dma_rvalid = (rd_owner_q == OWN_DMA);
    assign bus.cpu_rdata  = rd_data_q;
    assign bus.dma_rdata  = rd_data_q;

    always_comb begin
        rd_owner_d   = OWN_NONE;
        rd_data_d    = rd_data_q;
        last_gnt_d   = last_gnt_q;
        starve_cnt_d = '0;

        if (cpu_gnt) begin
            last_gnt_d = 1'b0;
        end else if (dma_gnt) begin
            last_gnt_d = 1'b1;
        end

        if (cpu_gnt && !bus.cpu_we) begin
            rd_owner_d = OWN_CPU;
            rd_data_d  = bus.mem_rdata;
        end else if (dma_gnt && !bus.dma_we) begin
            rd_owner_d = OWN_DMA;
            rd_data_d  = bus.mem_rdata;
        end

        // Denied DMA cycles accumulate and saturate; any grant or dropped request clears.
        if (bus.dma_req && !dma_gnt) begin
            starve_cnt_d = starved ? starve_cnt_q : starve_cnt_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_owner_q   <= OWN_NONE;
            rd_data_q    <= '0;
            last_gnt_q   <= 1'b1;
            starve_cnt_q <= '0;
        end else begin
            rd_owner_q   <= rd_owner_d;
            rd_data_q    <= rd_data_d;
            last_gnt_q   <= last_gnt_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end
endmodule
